// File: rtl/tick_sched_pkg.sv
// Purpose: shared types and constants for the tick scheduler and its channels.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package tick_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // Programmed period value that stops a channel instead of starting it.
    localparam int PER_ZERO = 0;

endpackage

// File: rtl/tick_channel.sv
// Purpose: one programmable tick channel counting base ticks, periodic or one-shot.
// Latency: tick strobes one cycle after the base_tick that exhausts the count; busy/done registered.
// Backpressure: none; a config write is always applied and overrides a coincident base tick.
//
// Ports:
//   clock, reset       system clock, async active-high reset
//   run                1: count base ticks, 0: hold count and state
//   base_tick          shared prescaler strobe
//   wr_en              config write targeted at this channel (already handshaked)
//   wr_period          new period in base ticks, 0 stops the channel
//   wr_oneshot         1: fire once then stop
//   tick, busy, done   1-cycle strobe, channel running, sticky one-shot completion
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int PER_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             base_tick,
    input  logic             wr_en,
    input  logic [PER_W-1:0] wr_period,
    input  logic             wr_oneshot,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    chan_state_t      state_q,   state_d;
    logic [PER_W-1:0] count_q,   count_d;
    logic [PER_W-1:0] period_q,  period_d;
    logic             oneshot_q, oneshot_d;
    logic             tick_q,    tick_d;
    logic             done_q,    done_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        done_d    = done_q;
        tick_d    = 1'b0;

        if (wr_en) begin
            // A write always restarts the channel; any base tick this cycle is dropped.
            period_d  = wr_period;
            oneshot_d = wr_oneshot;
            done_d    = 1'b0;
            if (wr_period == PER_W'(PER_ZERO)) begin
                state_d = IDLE;
                count_d = '0;
            end else begin
                state_d = RUN;
                count_d = wr_period;
            end
        end else if (state_q == RUN && run && base_tick) begin
            if (count_q == PER_W'(1)) begin
                tick_d = 1'b1;
                if (oneshot_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    count_d = period_q;
                end
            end else begin
                count_d = count_q - PER_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            oneshot_q <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    assign tick = tick_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: rtl/tick_scheduler.sv
// Purpose: shared power-of-two prescaler feeding NUM_CH programmable clock-enable tick channels.
// Latency: base_tick one cycle after prescaler wrap; channel tick one cycle after the base_tick it uses.
// Backpressure: cfg_ready is high from the first clock after reset; writes are never stalled.
//
// Ports:
//   clock, reset                      system clock, async active-high reset
//   run                               1: prescaler and channels advance, 0: freeze
//   cfg_valid/cfg_ready               config write handshake
//   cfg_ch, cfg_period, cfg_oneshot   target channel, period (0 = stop), one-shot mode
//   base_tick                         prescaler wrap strobe
//   tick, busy, done                  per-channel strobe, running flag, sticky one-shot done
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int PRE_BITS = 17,
    parameter int NUM_CH   = 4,
    parameter int PER_W    = 8,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    output logic              base_tick,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    logic [PRE_BITS-1:0] pre_q,       pre_d;
    logic                base_tick_q, base_tick_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                cfg_accept;

    always_comb begin
        pre_d       = pre_q;
        base_tick_d = 1'b0;
        cfg_ready_d = 1'b1;
        if (run) begin
            pre_d       = pre_q + PRE_BITS'(1);
            // Registered strobe: high in the cycle after the all-ones -> 0 wrap.
            base_tick_d = (pre_q == {PRE_BITS{1'b1}});
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q       <= '0;
            base_tick_q <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            base_tick_q <= base_tick_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_accept = cfg_valid && cfg_ready_q;
    assign cfg_ready  = cfg_ready_q;
    assign base_tick  = base_tick_q;

    // An out-of-range cfg_ch matches no channel: handshake completes, nothing changes.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_en;
        assign wr_en = cfg_accept && (32'(cfg_ch) == i);

        tick_channel #(
            .PER_W (PER_W)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .run        (run),
            .base_tick  (base_tick_q),
            .wr_en      (wr_en),
            .wr_period  (cfg_period),
            .wr_oneshot (cfg_oneshot),
            .tick       (tick[i]),
            .busy       (busy[i]),
            .done       (done[i])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

    localparam int PRE_BITS = 2;
    localparam int NUM_CH   = 4;
    localparam int PER_W    = 4;
    localparam int CH_W     = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [PER_W-1:0]  cfg_period = '0;
    logic              cfg_oneshot = 1'b0;
    logic              base_tick;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    tick_scheduler #(
        .PRE_BITS (PRE_BITS),
        .NUM_CH   (NUM_CH),
        .PER_W    (PER_W),
        .CH_W     (CH_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .base_tick   (base_tick),
        .tick        (tick),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Cycle index: number of rising edges since the last reset release.
    int cyc;
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int tests = 0;
    int fails = 0;

    // Scoreboard: expected cycle numbers of each strobe, in order.
    int exp_tick[NUM_CH][$];
    int exp_base[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a strobe.
    always @(negedge clock) begin
        if (!reset) begin
            if (base_tick) begin
                if (exp_base.size() == 0) chk("base_tick_unexpected", cyc, -1);
                else                      chk("base_tick_cycle", cyc, exp_base.pop_front());
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (tick[i]) begin
                    if (exp_tick[i].size() == 0)
                        chk($sformatf("tick%0d_unexpected", i), cyc, -1);
                    else
                        chk($sformatf("tick%0d_cycle", i), cyc, exp_tick[i].pop_front());
                end
            end
        end
    end

    task automatic to_cyc(input int k);
        while (cyc < k) @(negedge clock);
    endtask

    // Drive a write at the current negedge; it is sampled on the next rising edge.
    task automatic cfg_write(input int ch, input int p, input bit os);
        cfg_valid   = 1'b1;
        cfg_ch      = CH_W'(ch);
        cfg_period  = PER_W'(p);
        cfg_oneshot = os;
        chk("cfg_ready_on_write", int'(cfg_ready), 1);
        @(negedge clock);
        cfg_valid   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"},      int'(tick), 0);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_done"},      int'(done), 0);
        chk({tag, "_base_tick"}, int'(base_tick), 0);
        chk({tag, "_cfg_ready"}, int'(cfg_ready), 0);
    endtask

    task automatic release_rst();
        repeat (3) @(negedge clock);
        chk_all_zero("in_reset");
        reset = 1'b0;
        #1;
        chk("cfg_ready_at_release", int'(cfg_ready), 0);
    endtask

    task automatic end_seg(input string tag);
        for (int i = 0; i < NUM_CH; i++) begin
            chk($sformatf("%s_missing_tick%0d", tag, i), exp_tick[i].size(), 0);
            exp_tick[i].delete();
        end
        chk({tag, "_missing_base_tick"}, exp_base.size(), 0);
        exp_base.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Segment A: reset values, first base tick, P=1 periodic, reset mid-run drops pending tick.
        exp_base.push_back(4);
        exp_base.push_back(8);
        exp_tick[0].push_back(5);
        release_rst();
        to_cyc(1);
        chk("cfg_ready_after_one_clock", int'(cfg_ready), 1);
        cfg_write(0, 1, 1'b0);              // accepted at edge 2
        to_cyc(8);
        @(posedge clock);                   // edge 9 would register tick[0]
        #1 reset = 1'b1;
        #1;
        chk_all_zero("mid_run_reset");
        end_seg("segA");

        // Segment B: periodic, one-shot, write on base_tick cycle, stop, out-of-range channel.
        for (int m = 1; m <= 13; m++) exp_base.push_back(4 * m);
        exp_tick[0].push_back(13);
        exp_tick[0].push_back(25);
        exp_tick[1].push_back(9);
        exp_tick[2].push_back(29);
        exp_tick[2].push_back(49);
        release_rst();
        to_cyc(1);
        cfg_write(0, 3, 1'b0);              // edge 2
        cfg_write(1, 2, 1'b1);              // edge 3
        chk("segB_busy_after_writes", int'(busy), 4'b0011);
        chk("segB_done_after_writes", int'(done), 0);
        to_cyc(8);
        cfg_write(2, 5, 1'b0);              // edge 9, coincides with a base tick
        chk("segB_busy_oneshot_end", int'(busy), 4'b0101);
        chk("segB_done_oneshot", int'(done), 4'b0010);
        to_cyc(20);
        chk("segB_done_sticky", int'(done), 4'b0010);
        cfg_write(1, 0, 1'b0);              // rewrite clears done
        chk("segB_done_cleared", int'(done), 0);
        chk("segB_busy_after_clear", int'(busy), 4'b0101);
        to_cyc(30);
        cfg_write(0, 0, 1'b0);              // stop ch0
        chk("segB_busy_ch0_stopped", int'(busy), 4'b0100);
        cfg_write(5, 1, 1'b0);              // no such channel
        chk("segB_busy_bad_ch", int'(busy), 4'b0100);
        chk("segB_done_bad_ch", int'(done), 0);
        to_cyc(53);
        #2 reset = 1'b1;
        end_seg("segB");

        // Segment C: run=0 pause of 10 clocks, write applied while frozen.
        exp_base.push_back(4);
        exp_base.push_back(8);
        for (int m = 0; m < 6; m++) exp_base.push_back(22 + 4 * m);
        exp_tick[3].push_back(9);
        exp_tick[3].push_back(27);
        exp_tick[3].push_back(35);
        exp_tick[3].push_back(43);
        exp_tick[1].push_back(23);
        release_rst();
        to_cyc(1);
        cfg_write(3, 2, 1'b0);              // edge 2
        to_cyc(10);
        run = 1'b0;                         // edges 11..20 frozen
        to_cyc(14);
        cfg_write(1, 1, 1'b1);              // edge 15, while frozen
        chk("segC_busy_write_frozen", int'(busy), 4'b1010);
        to_cyc(20);
        run = 1'b1;
        to_cyc(24);
        chk("segC_busy_after_oneshot", int'(busy), 4'b1000);
        chk("segC_done_after_oneshot", int'(done), 4'b0010);
        to_cyc(45);
        end_seg("segC");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
